fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; power of two, minimum 2.
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  fetch stage offers an instruction this cycle.
REQ-005 in_inst  input  32  fetched instruction word.
REQ-006 in_pc  input  `XLEN  PC of the offered instruction.
REQ-007 in_npc  input  `XLEN  predicted next PC of the offered instruction.
REQ-008 in_ready  output  1  buffer accepts an offer this cycle.
REQ-009 flush  input  1  squash all entries (certain-branch or ROB redirect).
REQ-010 out_valid  output  1  head entry is presented to decode.
REQ-011 out_inst / out_pc / out_npc  output  32 / `XLEN / `XLEN  head entry fields.
REQ-012 out_ready  input  1  decode consumes the head this cycle.
REQ-013 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-014 fetch_stall  output  1  asserted when count == DEPTH; drives the fetch stage's hold.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries with head and tail pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
REQ-016 Empty SHALL be head == tail; full SHALL be equal index bits with differing wrap bits.
REQ-017 in_ready SHALL equal !full and SHALL NOT depend on out_ready (no same-cycle slot reuse when full).
REQ-018 Enqueue SHALL occur at posedge when in_valid && in_ready && !flush: write the entry at tail, then tail+1 modulo 2*DEPTH.
REQ-019 out_valid SHALL equal !empty; out_* SHALL be driven combinationally from the head entry registers.
REQ-020 Dequeue SHALL occur at posedge when out_valid && out_ready && !flush: head+1 modulo 2*DEPTH.
REQ-021 Simultaneous enqueue and dequeue SHALL leave count unchanged and move both pointers.
REQ-022 No bypass: an instruction enqueued at edge N SHALL first appear on out_* in the cycle after edge N (one-cycle latency, also when empty).
REQ-023 When out_valid is low, out_inst SHALL read `NOP and out_pc/out_npc SHALL read 0.
REQ-024 flush SHALL have priority: at posedge with flush high, head and tail SHALL be reset to 0, and any enqueue or dequeue in that cycle SHALL be discarded.
REQ-025 After a flush edge, out_valid SHALL be 0 and in_ready SHALL be 1 in the following cycle.
REQ-026 count SHALL equal tail - head (pointer-width arithmetic) and SHALL never exceed DEPTH.
REQ-027 Entries SHALL hold their values while out_ready is low (head stable under back-pressure).

Reset
REQ-028 While reset is high, asynchronously: head = tail = 0, count = 0, out_valid = 0, in_ready = 1, fetch_stall = 0, out_inst = `NOP, out_pc = out_npc = 0.
REQ-029 Entry contents SHALL NOT require reset; they SHALL NOT be visible until written.
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Verification
REQ-031 Single pass: enqueue inst 32'h00A00093, pc 32'h0000_1111, npc 32'h0000_1115, out_ready=1 -> out_valid one cycle later with those values, then empty.
REQ-032 Fill: DEPTH=4, out_ready=0, offer pc 0x100,0x104,0x108,0x10C,0x110 -> first four accepted, in_ready=0 and fetch_stall=1 at count=4, 0x110 held until out_ready=1 and then drained in order.
REQ-033 Wrap-around: stream 12 instructions with out_ready toggling every cycle -> every PC delivered exactly once, in order, count never exceeds 4.
REQ-034 Full with simultaneous out_ready and in_valid -> dequeue only; count goes 4 to 3; the offer is accepted on the next edge.
REQ-035 Flush with 3 entries plus in_valid and out_ready high -> next cycle count=0, out_valid=0, in_ready=1; the flushed-cycle offer is absent.
REQ-036 Assert reset asynchronously between edges with count=2 -> count=0 and out_valid=0 before the next posedge.

Source files
------------

// File: rtl/fetch_buffer.sv
// Circular instruction buffer between fetch and decode: wrap-bit pointers,
// flush-priority squash, no bypass, NOP/zero presented when empty.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NOP
`define NOP 32'h0000_0013
`endif

module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_inst,
  input  logic [`XLEN-1:0]         in_pc,
  input  logic [`XLEN-1:0]         in_npc,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [31:0]              out_inst,
  output logic [`XLEN-1:0]         out_pc,
  output logic [`XLEN-1:0]         out_npc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     fetch_stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic               empty_s, full_s;
  logic               enq_s, deq_s;
  logic [AW-1:0]      head_idx_s, tail_idx_s;

  logic [31:0]        inst_mem_q [DEPTH];
  logic [`XLEN-1:0]   pc_mem_q   [DEPTH];
  logic [`XLEN-1:0]   npc_mem_q  [DEPTH];

  // Occupancy decode and pointer next-state; flush overrides any transfer.
  always_comb begin
    head_idx_s = head_q[AW-1:0];
    tail_idx_s = tail_q[AW-1:0];
    empty_s    = (head_q == tail_q);
    full_s     = (head_idx_s == tail_idx_s) && (head_q[AW] != tail_q[AW]);
    enq_s      = in_valid && !full_s && !flush;
    deq_s      = !empty_s && out_ready && !flush;
    head_d     = head_q;
    tail_d     = tail_q;
    if (flush) begin
      head_d = PTR_ZERO;
      tail_d = PTR_ZERO;
    end else begin
      if (deq_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      if (enq_s) begin
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= PTR_ZERO;
      tail_q <= PTR_ZERO;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry storage; never reset, only visible once written and between head and tail.
  always_ff @(posedge clock) begin
    if (enq_s) begin
      inst_mem_q[tail_idx_s] <= in_inst;
      pc_mem_q[tail_idx_s]   <= in_pc;
      npc_mem_q[tail_idx_s]  <= in_npc;
    end
  end

  // Head presentation and status outputs.
  always_comb begin
    in_ready    = !full_s;
    fetch_stall = full_s;
    out_valid   = !empty_s;
    count       = tail_q - head_q;
    if (!empty_s) begin
      out_inst = inst_mem_q[head_idx_s];
      out_pc   = pc_mem_q[head_idx_s];
      out_npc  = npc_mem_q[head_idx_s];
    end else begin
      out_inst = `NOP;
      out_pc   = {`XLEN{1'b0}};
      out_npc  = {`XLEN{1'b0}};
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized and directed bench for fetch_buffer against a queue-based model.
module tb_fetch_buffer;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] in_inst, in_pc, in_npc;
  logic        in_ready, out_valid, fetch_stall;
  logic [31:0] out_inst, out_pc, out_npc;
  logic [2:0]  count;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } ent_t;

  ent_t model_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   accepted;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_inst(in_inst),
    .in_pc(in_pc), .in_npc(in_npc), .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_npc(out_npc), .out_ready(out_ready), .count(count),
    .fetch_stall(fetch_stall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Check every output against the model, then advance the model across one edge.
  task automatic step();
    int sz;
    ent_t e;
    #1;
    sz = model_q.size();
    if (sz > 0) e = model_q[0];
    else e = '{inst: 32'h0000_0013, pc: 32'h0, npc: 32'h0};
    chk("out_valid",   64'(out_valid),   64'(sz > 0));
    chk("in_ready",    64'(in_ready),    64'(sz < DEPTH));
    chk("fetch_stall", 64'(fetch_stall), 64'(sz == DEPTH));
    chk("count",       64'(count),       64'(sz));
    chk("out_inst",    64'(out_inst),    64'(e.inst));
    chk("out_pc",      64'(out_pc),      64'(e.pc));
    chk("out_npc",     64'(out_npc),     64'(e.npc));
    accepted = in_valid && (sz < DEPTH) && !flush;
    if (flush) model_q.delete();
    else begin
      if (sz > 0 && out_ready) void'(model_q.pop_front());
      if (accepted) model_q.push_back('{inst: in_inst, pc: in_pc, npc: in_npc});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_npc   = pc + 32'd4;
    in_inst  = {pc[15:0], 16'h0093} ^ 32'h0A00_0000;
  endtask

  initial begin
    int n, guard;
    logic [31:0] pc;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 32'h0; in_npc = 32'h0;
    #7;
    step();                                   // reset state while reset held
    reset = 1'b0;
    step();

    // Single pass
    in_valid = 1'b1; in_inst = 32'h00A0_0093; in_pc = 32'h0000_1111; in_npc = 32'h0000_1115;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();

    // Fill to full, hold the fifth offer, then dequeue-only and accept next edge
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin offer(32'h100 + 32'(4 * i)); step(); end
    offer(32'h110);
    step(); step();
    chk("fill_held_fifth", 64'(accepted), 64'd0);
    out_ready = 1'b1;
    step();
    chk("full_deq_only", 64'(accepted), 64'd0);
    step();
    chk("next_edge_accept", 64'(accepted), 64'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Wrap-around with toggling out_ready
    pc = 32'h200; n = 0; guard = 0; out_ready = 1'b0;
    while (n < 12 && guard < 100) begin
      offer(pc);
      out_ready = ~out_ready;
      step();
      if (accepted) begin n++; pc = pc + 32'd4; end
      guard++;
    end
    chk("wrap_guard", 64'(n), 64'd12);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Flush with three entries plus concurrent offer and consume
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin offer(32'h300 + 32'(4 * i)); step(); end
    in_valid = 1'b0;
    step();
    offer(32'h400); out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    step();

    // Asynchronous reset between edges with two entries
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin offer(32'h500 + 32'(4 * i)); step(); end
    in_valid = 1'b0;
    #1;
    chk("pre_reset_count", 64'(count), 64'd2);
    reset = 1'b1;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_inst",  64'(out_inst), 64'h13);
    model_q.delete();
    @(posedge clock); #2;
    reset = 1'b0;
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 15) == 0;
      in_inst   = $urandom;
      in_pc     = $urandom;
      in_npc    = $urandom;
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
